// File: rtl/sipo_sched.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_sched
//  Purpose  : Round-robin scheduler sharing one external WIDTH-bit SIPO shift
//             register between two requesters. A granted word is serialised
//             MSB-first into the SIPO. The SIPO parallel output is then
//             captured and returned on a valid/ready response port with the
//             requester id and a readback-match flag.
//  Revision : 1.0 - initial release
// ============================================================================
module sipo_sched #(
  parameter int WIDTH = 23,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic             sipo_clr,
  output logic             sipo_shift,
  output logic             sipo_din,
  input  logic [WIDTH-1:0] sipo_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_match,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
  // With GAP==0 the WAIT state is never entered, so the load value is moot.
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_SHIFT   = 3'd2,
    S_CAPTURE = 3'd3,
    S_RESP    = 3'd4,
    S_WAIT    = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;        // id of the most recent grant
  logic [CNT_W-1:0] cnt_q, cnt_d;          // bit index being shifted out
  logic [GAP_W-1:0] gap_q, gap_d;          // remaining idle cycles in WAIT
  logic [WIDTH-1:0] word_q, word_d;        // accepted word
  logic             id_q, id_d;            // accepted requester
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_id_q, rsp_id_d;
  logic             rsp_match_q, rsp_match_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             clr_q, clr_d;
  logic             shift_q, shift_d;
  logic             din_q, din_d;

  logic [1:0]       grant;
  logic             accept;

  // Round-robin grant: a lone requester always wins, a tie goes to the one
  // that was not served last.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign req_ready = grant & {2{state_q == S_IDLE}};
  assign accept    = |(req_valid & req_ready);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    word_d      = word_q;
    id_d        = id_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_match_d = rsp_match_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          word_d  = req_ready[1] ? req_data1 : req_data0;
          id_d    = req_ready[1];
          last_d  = req_ready[1];
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d   = CNT_LOAD;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_CAPTURE: begin
        rsp_data_d  = sipo_q;
        rsp_match_d = (sipo_q == word_q);
        rsp_id_d    = id_q;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          gap_d   = GAP_LOAD;
          state_d = (GAP > 0) ? S_WAIT : S_IDLE;
        end
      end
      S_WAIT: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // SIPO controls and rsp_valid are decoded from the next state and
    // registered, so the SIPO sees clean flop outputs.
    clr_d       = (state_d == S_CLEAR);
    shift_d     = (state_d == S_SHIFT);
    din_d       = shift_d & word_q[cnt_d];
    rsp_valid_d = (state_d == S_RESP);
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      gap_q       <= '0;
      word_q      <= '0;
      id_q        <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= 1'b0;
      rsp_match_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      clr_q       <= 1'b0;
      shift_q     <= 1'b0;
      din_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      word_q      <= word_d;
      id_q        <= id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_match_q <= rsp_match_d;
      rsp_valid_q <= rsp_valid_d;
      clr_q       <= clr_d;
      shift_q     <= shift_d;
      din_q       <= din_d;
    end
  end

  assign sipo_clr   = clr_q;
  assign sipo_shift = shift_q;
  assign sipo_din   = din_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_match  = rsp_match_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sipo_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sipo_sched
//  Purpose  : Self-checking bench for sipo_sched with behavioural SIPO models.
//             Instance u_dut uses GAP=0, instance u_dut_gap uses GAP=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sipo_sched;

  localparam int W = 23;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- GAP=0 instance ----------------
  logic         rst_n = 1'b1;
  logic [1:0]   req_valid = '0;
  logic [1:0]   req_ready;
  logic [W-1:0] req_data0 = '0, req_data1 = '0;
  logic         sipo_clr, sipo_shift, sipo_din;
  logic [W-1:0] sipo_q = '0;
  logic         rsp_valid, rsp_id, rsp_match, busy;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_data;
  logic         stuck0 = 1'b0;

  sipo_sched #(.WIDTH(W), .GAP(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data0(req_data0), .req_data1(req_data1), .sipo_clr(sipo_clr),
    .sipo_shift(sipo_shift), .sipo_din(sipo_din), .sipo_q(sipo_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_match(rsp_match), .busy(busy)
  );

  // SIPO model, optionally with bit 3 stuck at 0. No reset: stale contents
  // must be removed by the scheduler's clear.
  always @(posedge clk) begin
    if (sipo_clr)        sipo_q <= '0;
    else if (sipo_shift) sipo_q <= stuck0 ? ({sipo_q[W-2:0], sipo_din} & ~(W'(1) << 3))
                                          : {sipo_q[W-2:0], sipo_din};
  end

  // ---------------- GAP=3 instance ----------------
  logic         g_rst_n = 1'b1;
  logic         g_valid0 = 1'b0, g_valid1 = 1'b0;
  logic [1:0]   g_req_valid;
  logic [1:0]   g_req_ready;
  logic [W-1:0] g_data0 = '0, g_data1 = '0;
  logic         g_clr, g_shift, g_din;
  logic [W-1:0] g_sipo_q = '0;
  logic         g_rsp_valid, g_rsp_id, g_rsp_match, g_busy;
  logic         g_rsp_ready = 1'b0;
  logic [W-1:0] g_rsp_data;

  assign g_req_valid = {g_valid1, g_valid0};

  sipo_sched #(.WIDTH(W), .GAP(3)) u_dut_gap (
    .clk(clk), .rst_n(g_rst_n), .req_valid(g_req_valid), .req_ready(g_req_ready),
    .req_data0(g_data0), .req_data1(g_data1), .sipo_clr(g_clr),
    .sipo_shift(g_shift), .sipo_din(g_din), .sipo_q(g_sipo_q),
    .rsp_valid(g_rsp_valid), .rsp_ready(g_rsp_ready), .rsp_id(g_rsp_id),
    .rsp_data(g_rsp_data), .rsp_match(g_rsp_match), .busy(g_busy)
  );

  always @(posedge clk) begin
    if (g_clr)        g_sipo_q <= '0;
    else if (g_shift) g_sipo_q <= {g_sipo_q[W-2:0], g_din};
  end

  // ---------------- checking helpers ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present a request, check the grant, and let the accept edge pass.
  task automatic do_accept(input logic [1:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1,
                           input logic stuck, input logic [1:0] exp_rdy, input string tag);
    @(posedge clk); #1;
    stuck0    = stuck;
    req_valid = v;
    req_data0 = d0;
    req_data1 = d1;
    @(negedge clk);
    check({tag, "_grant"}, 64'(req_ready), 64'(exp_rdy));
    @(posedge clk); #1;
    req_valid = 2'b00;
    req_data0 = ~d0;   // must be ignored after the accept edge
    req_data1 = ~d1;
  endtask

  // From cycle 1 after accept, wait for the response and check it.
  task automatic collect_rsp(input logic exp_id, input logic [W-1:0] exp_data,
                             input logic exp_match, input string tag);
    int lat, nshift, nclr;
    logic clr1;
    lat = 0; nshift = 0; nclr = 0; clr1 = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (sipo_shift) nshift++;
      if (sipo_clr)   nclr++;
      if (k == 1)     clr1 = sipo_clr;
      if (sipo_clr && sipo_shift) check({tag, "_clr_shift_excl"}, 64'(1), 64'(0));
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(W + 3));
    check({tag, "_nshift"}, 64'(nshift), 64'(W));
    check({tag, "_nclr"}, 64'(nclr), 64'(1));
    check({tag, "_clr_cycle1"}, 64'(clr1), 64'(1));
    check({tag, "_rsp_id"}, 64'(rsp_id), 64'(exp_id));
    check({tag, "_rsp_data"}, 64'(rsp_data), 64'(exp_data));
    check({tag, "_rsp_match"}, 64'(rsp_match), 64'(exp_match));
  endtask

  typedef struct {
    logic [1:0]   valid;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         stuck;
    logic [1:0]   exp_rdy;
    logic         exp_id;
    logic [W-1:0] exp_data;
    logic         exp_match;
  } vec_t;

  vec_t tbl [10];

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
  } exp_t;

  exp_t g_q[$];
  exp_t g_e;
  int   g_nrsp   = 0;
  int   g_gap    = -1;
  logic g_done   = 1'b0;
  int   t0, t1, tw;

  initial begin
    // Round-robin pointer starts at 1, so requester 0 wins the first tie.
    tbl[0] = '{2'b01, 23'h5A5A5A, 23'h000000, 1'b0, 2'b01, 1'b0, 23'h5A5A5A, 1'b1};
    tbl[1] = '{2'b10, 23'h000000, 23'h123456, 1'b0, 2'b10, 1'b1, 23'h123456, 1'b1};
    tbl[2] = '{2'b11, 23'h000001, 23'h7FFFFF, 1'b0, 2'b01, 1'b0, 23'h000001, 1'b1};
    tbl[3] = '{2'b11, 23'h000001, 23'h7FFFFF, 1'b0, 2'b10, 1'b1, 23'h7FFFFF, 1'b1};
    tbl[4] = '{2'b11, 23'h000001, 23'h7FFFFF, 1'b0, 2'b01, 1'b0, 23'h000001, 1'b1};
    tbl[5] = '{2'b11, 23'h000001, 23'h7FFFFF, 1'b0, 2'b10, 1'b1, 23'h7FFFFF, 1'b1};
    tbl[6] = '{2'b01, 23'h00000F, 23'h000000, 1'b1, 2'b01, 1'b0, 23'h000007, 1'b0};
    tbl[7] = '{2'b01, 23'h7FFFFF, 23'h000000, 1'b0, 2'b01, 1'b0, 23'h7FFFFF, 1'b1};
    tbl[8] = '{2'b10, 23'h000000, 23'h000000, 1'b0, 2'b10, 1'b1, 23'h000000, 1'b1};
    tbl[9] = '{2'b11, 23'h2AAAAA, 23'h555555, 1'b0, 2'b01, 1'b0, 23'h2AAAAA, 1'b1};

    // Reset both instances.
    #2;
    rst_n   = 1'b0;
    g_rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({req_ready, sipo_clr, sipo_shift, sipo_din, rsp_valid,
                                rsp_id, rsp_match, busy, rsp_data}), 64'(0));
    check("reset_gap_outputs", 64'({g_req_ready, g_clr, g_shift, g_din, g_rsp_valid,
                                    g_rsp_id, g_rsp_match, g_busy, g_rsp_data}), 64'(0));
    rst_n   = 1'b1;
    g_rst_n = 1'b1;

    // Table-driven transactions with rsp_ready held high.
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      do_accept(tbl[i].valid, tbl[i].d0, tbl[i].d1, tbl[i].stuck, tbl[i].exp_rdy,
                $sformatf("vec%0d", i));
      collect_rsp(tbl[i].exp_id, tbl[i].exp_data, tbl[i].exp_match, $sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d_back_idle", i), 64'({busy, rsp_valid}), 64'(0));
    end

    // Response backpressure while requester 0 keeps a request pending.
    rsp_ready = 1'b0;
    do_accept(2'b11, 23'h0F0F0F, 23'h3C3C3C, 1'b0, 2'b10, "stall");
    req_valid = 2'b01;
    req_data0 = 23'h0F0F0F;
    collect_rsp(1'b1, 23'h3C3C3C, 1'b1, "stall");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_rsp_hold", 64'({rsp_valid, rsp_id, rsp_match, rsp_data}),
            64'({1'b1, 1'b1, 1'b1, 23'h3C3C3C}));
      check("stall_no_ready", 64'(req_ready), 64'(0));
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_still_resp", 64'({rsp_valid, busy}), 64'(2'b11));
    @(negedge clk);
    check("stall_release_idle", 64'({busy, req_ready}), 64'({1'b0, 2'b01}));
    @(posedge clk); #1;
    req_valid = 2'b00;
    collect_rsp(1'b0, 23'h0F0F0F, 1'b1, "held");
    @(negedge clk);
    check("held_back_idle", 64'({busy, rsp_valid}), 64'(0));

    // Asynchronous reset during the tenth shift cycle.
    do_accept(2'b01, 23'h6B6B6B, 23'h000000, 1'b0, 2'b01, "abort");
    repeat (10) @(posedge clk);
    #2;
    check("abort_midframe_shift", 64'({busy, sipo_shift}), 64'(2'b11));
    rst_n = 1'b0;
    #1;
    check("abort_async_outputs", 64'({req_ready, sipo_clr, sipo_shift, sipo_din, rsp_valid,
                                      rsp_id, rsp_match, busy, rsp_data}), 64'(0));
    repeat (2) @(negedge clk);
    check("abort_no_response", 64'({rsp_valid, busy}), 64'(0));
    rst_n = 1'b1;
    do_accept(2'b11, 23'h1ACE55, 23'h2BCD01, 1'b0, 2'b01, "postrst");
    collect_rsp(1'b0, 23'h1ACE55, 1'b1, "postrst");
    @(negedge clk);
    check("postrst_back_idle", 64'({busy, rsp_valid}), 64'(0));

    // GAP=3 instance: random traffic from both requesters with random stalls.
    fork
      begin
        fork
          begin
            for (int n = 0; n < 100; n++) begin
              @(posedge clk); #1;
              g_valid0 = 1'b1;
              g_data0  = W'($urandom);
              t0 = 0;
              forever begin
                @(negedge clk);
                if (g_req_ready[0]) break;
                t0++;
                if (t0 > 2000) begin
                  check("gap_req0_timeout", 64'(1), 64'(0));
                  break;
                end
              end
              @(posedge clk); #1;
              g_valid0 = 1'b0;
              g_data0  = ~g_data0;
              repeat ($urandom_range(0, 3)) @(posedge clk);
            end
          end
          begin
            for (int n = 0; n < 100; n++) begin
              @(posedge clk); #1;
              g_valid1 = 1'b1;
              g_data1  = W'($urandom);
              t1 = 0;
              forever begin
                @(negedge clk);
                if (g_req_ready[1]) break;
                t1++;
                if (t1 > 2000) begin
                  check("gap_req1_timeout", 64'(1), 64'(0));
                  break;
                end
              end
              @(posedge clk); #1;
              g_valid1 = 1'b0;
              g_data1  = ~g_data1;
              repeat ($urandom_range(0, 2)) @(posedge clk);
            end
          end
        join
        tw = 0;
        while (g_nrsp < 200 && tw < 3000) begin
          @(negedge clk);
          tw++;
        end
        @(negedge clk);
        g_done = 1'b1;
      end
      begin
        while (!g_done) begin
          @(posedge clk); #1;
          g_rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        while (!g_done) begin
          @(negedge clk);
          if (g_clr || g_shift)
            check("gap_clr_shift_excl", 64'(g_clr & g_shift), 64'(0));
          if (|(g_req_valid & g_req_ready))
            g_q.push_back({g_req_ready[1], g_req_ready[1] ? g_data1 : g_data0});
          if (g_rsp_valid && g_rsp_ready) begin
            if (g_q.size() == 0) begin
              check("gap_rsp_unexpected", 64'(1), 64'(0));
            end else begin
              g_e = g_q.pop_front();
              check("gap_rsp_id", 64'(g_rsp_id), 64'(g_e.id));
              check("gap_rsp_data", 64'(g_rsp_data), 64'(g_e.data));
              check("gap_rsp_match", 64'(g_rsp_match), 64'(1));
            end
            g_nrsp++;
            g_gap = 3;
          end else if (g_gap > 0) begin
            check("gap_wait_no_ready", 64'({g_busy, g_req_ready}), 64'({1'b1, 2'b00}));
            g_gap--;
          end else if (g_gap == 0) begin
            check("gap_wait_done_idle", 64'(g_busy), 64'(0));
            g_gap = -1;
          end
        end
      end
    join

    check("gap_rsp_count", 64'(g_nrsp), 64'(200));
    check("gap_queue_empty", 64'(g_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
